// File: rtl/rv_isa_pkg.sv
// Shared RV32I opcode constants, the padding NOP word and the loader FSM state type
// for the instruction assembler.
package rv_isa_pkg;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_S     = 7'h23;
    localparam logic [6:0] OP_SB    = 7'h63;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_DONE
    } asm_state_t;

endpackage

// File: rtl/rv_instr_encode.sv
// Combinational field-to-word encoder for the R/I/S/SB/U/UJ formats; flags
// opcodes outside the supported set as illegal.
module rv_instr_encode
    import rv_isa_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (opcode)
            OP_R:
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_I, OP_LOAD, OP_JALR:
                word = {imm[11:0], rs1, funct3, rd, opcode};
            OP_S:
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            OP_SB:
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            OP_LUI, OP_AUIPC:
                word = {imm[31:12], rd, opcode};
            OP_JAL:
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default:
                legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_assembler.sv
// Streams decoded instruction fields into sequential instruction-memory writes.
// Optional ASM_NOP_PAD_EN: fill the remaining words of a load with NOPs after the last beat.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// LOAD  | accepting field beats, one memory write per legal beat
// PAD   | writing NOP_WORD until DEPTH words are written (ASM_NOP_PAD_EN only)
// DONE  | load complete, waiting for start
module instr_assembler
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [6:0]                   opcode,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [2:0]                   funct3,
    input  logic [6:0]                   funct7,
    input  logic [31:0]                  imm,
    output logic                         imem_we,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic [31:0]                  imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   words,
    output logic                         busy,
    output logic                         done,
    output logic                         err_illegal
);

    localparam int WORDS_W = $clog2(DEPTH+1);

    asm_state_t         state, state_n;
    logic [WORDS_W-1:0] words_n;
    logic               err_n;
    logic               wr;
    logic [31:0]        wr_data;
    logic [ADDR_W-1:0]  wr_addr;
    logic [31:0]        enc_word;
    logic               enc_legal;
    logic               accept;

    rv_instr_encode u_encode (
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    assign in_ready = (state == ST_LOAD) & ~start & (words < WORDS_W'(DEPTH));
    assign accept   = in_valid & in_ready;
    assign busy     = (state == ST_LOAD) | (state == ST_PAD);
    assign done     = (state == ST_DONE);
    // Byte address of the next word; wraps silently at the ADDR_W boundary.
    assign wr_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'({words, 2'b00});

    always_comb begin
        state_n = state;
        words_n = words;
        err_n   = err_illegal;
        wr      = 1'b0;
        wr_data = '0;
        if (start) begin
            state_n = ST_LOAD;
            words_n = '0;
            err_n   = 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (enc_legal) begin
                            wr      = 1'b1;
                            wr_data = enc_word;
                            words_n = words + WORDS_W'(1);
                        end else begin
                            err_n = 1'b1;
                        end
                        if (words_n == WORDS_W'(DEPTH)) begin
                            state_n = ST_DONE;
                        end else if (in_last) begin
`ifdef ASM_NOP_PAD_EN
                            state_n = ST_PAD;
`else
                            state_n = ST_DONE;
`endif
                        end
                    end
                end
`ifdef ASM_NOP_PAD_EN
                ST_PAD: begin
                    wr      = 1'b1;
                    wr_data = NOP_WORD;
                    words_n = words + WORDS_W'(1);
                    if (words_n == WORDS_W'(DEPTH)) begin
                        state_n = ST_DONE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            words       <= '0;
            err_illegal <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= ADDR_W'(BASE_ADDR);
            imem_wdata  <= '0;
        end else begin
            state       <= state_n;
            words       <= words_n;
            err_illegal <= err_n;
            imem_we     <= wr;
            if (wr) begin
                imem_addr  <= wr_addr;
                imem_wdata <= wr_data;
            end else if (start) begin
                imem_addr  <= ADDR_W'(BASE_ADDR);
            end
        end
    end

endmodule
